// File: rtl/popcount_seq.sv
// Sequential population counter: examines CHUNK bits per cycle of a latched word,
// counting ones or zeros, and optionally accumulates into a saturating running total.
module popcount_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int TOTW  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             mode,
  input  logic                             accum_en,
  input  logic                             clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(WIDTH+1)-1:0]       out_count,
  output logic [TOTW-1:0]                  out_total,
  output logic                             sat
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Sum width leaves one headroom bit above whichever of total/count is wider.
  localparam int SW = ((TOTW > CW) ? TOTW : CW) + 1;
  localparam logic [SW-1:0] TMAX = {{(SW - TOTW){1'b0}}, {TOTW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of bits in one chunk that match the selected value (zeros=1 counts zeros).
  function automatic logic [CW-1:0] chunk_count(input logic [CHUNK-1:0] bits, input logic zeros);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < CHUNK; i++) begin
      acc = acc + CW'(bits[i] ^ zeros);
    end
    return acc;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WIDTH-1:0]  data_r;
  logic              mode_r;
  logic              accum_r;
  logic [IW-1:0]     idx_r;
  logic [CW-1:0]     part_r;
  logic [CW-1:0]     out_count_r;
  logic [TOTW-1:0]   out_total_r;
  logic              sat_r;

  logic [CHUNK-1:0]  chunk_s;
  logic              last_s;
  logic [CW-1:0]     next_part_s;
  logic [SW-1:0]     sum_s;
  logic              ovf_s;
  logic [TOTW-1:0]   total_upd_s;

  assign chunk_s     = data_r[int'(idx_r) * CHUNK +: CHUNK];
  assign last_s      = (idx_r == IW'(N - 1));
  assign next_part_s = part_r + chunk_count(chunk_s, mode_r);
  assign sum_s       = SW'(out_total_r) + SW'(next_part_s);
  assign ovf_s       = (sum_s > TMAX);
  assign total_upd_s = ovf_s ? TMAX[TOTW-1:0] : sum_s[TOTW-1:0];

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_count = out_count_r;
  assign out_total = out_total_r;
  assign sat       = sat_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = COUNT;
        else          state_nxt_s = IDLE;
      end
      COUNT: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = COUNT;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Word capture, chunk walk and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r      <= '0;
      mode_r      <= 1'b0;
      accum_r     <= 1'b0;
      idx_r       <= '0;
      part_r      <= '0;
      out_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r  <= in_data;
            mode_r  <= mode;
            accum_r <= accum_en;
            idx_r   <= '0;
            part_r  <= '0;
          end
        end
        COUNT: begin
          part_r <= next_part_s;
          idx_r  <= idx_r + IW'(1);
          if (last_s) out_count_r <= next_part_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Running total; a clear on the same edge as an update takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_total_r <= '0;
      sat_r       <= 1'b0;
    end else if (clear) begin
      out_total_r <= '0;
      sat_r       <= 1'b0;
    end else if ((state_r == COUNT) && last_s && accum_r) begin
      out_total_r <= total_upd_s;
      sat_r       <= sat_r | ovf_s;
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: a default instance and a TOTW=5 instance share stimulus.
module tb_popcount_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, mode, accum_en, clear, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, sat;
  logic [4:0]  out_count;
  logic [15:0] out_total;
  logic        in_ready5, out_valid5, sat5;
  logic [4:0]  out_count5;
  logic [4:0]  out_total5;

  popcount_seq #(.WIDTH(16), .CHUNK(4), .TOTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .accum_en(accum_en), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_total(out_total), .sat(sat)
  );

  popcount_seq #(.WIDTH(16), .CHUNK(4), .TOTW(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
    .mode(mode), .accum_en(accum_en), .clear(clear), .out_valid(out_valid5),
    .out_ready(out_ready), .out_count(out_count5), .out_total(out_total5), .sat(sat5)
  );

  typedef struct {
    int cnt;
    int t16;
    bit s16;
    int t5;
    bit s5;
    int acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   m_t16, m_t5;
  bit   m_s16, m_s5;
  bit   rnd;
  bit   prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int popc(input logic [15:0] d, input logic m);
    int c = 0;
    for (int i = 0; i < 16; i++) if (d[i] != m) c++;
    return c;
  endfunction

  task automatic model_zero();
    m_t16 = 0; m_t5 = 0; m_s16 = 1'b0; m_s5 = 1'b0;
  endtask

  // Issue one word (called just after a negedge, returns just after a negedge).
  task automatic send(input logic [15:0] d, input logic m, input logic a,
                      input bit track, input bit clr_done);
    int   w = 0;
    int   c;
    exp_t e;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1; in_data = d; mode = m; accum_en = a;
    c = popc(d, m);
    if (track) begin
      if (a) begin
        if (m_t16 + c > 65535) begin m_t16 = 65535; m_s16 = 1'b1; end
        else m_t16 = m_t16 + c;
        if (m_t5 + c > 31) begin m_t5 = 31; m_s5 = 1'b1; end
        else m_t5 = m_t5 + c;
      end
      if (clr_done) model_zero();
      e = '{c, m_t16, m_s16, m_t5, m_s5, cyc + 1};
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    mode     = 1'($urandom_range(0, 1));
    accum_en = 1'($urandom_range(0, 1));
    if (clr_done) begin
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
  endtask

  task automatic do_clear();
    int w = 0;
    while ((q.size() != 0 || !in_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("clear_wait_idle", q.size(), 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
    check("clear_total16", out_total, 0);
    check("clear_sat16", sat, 0);
    check("clear_total5", out_total5, 0);
    check("clear_sat5", sat5, 0);
  endtask

  // Monitor: latency on every out_valid rise, scoreboard compare on every handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (out_valid && !prev_v && q.size() > 0) check("latency", cyc - q[0].acc, 4);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result_qsize", q.size(), 1);
        end else begin
          e = q.pop_front();
          check("out_count", out_count, e.cnt);
          check("out_count5", out_count5, e.cnt);
          check("out_valid5", out_valid5, 1);
          check("out_total", out_total, e.t16);
          check("sat", sat, e.s16);
          check("out_total5", out_total5, e.t5);
          check("sat5", sat5, e.s5);
        end
      end
    end
    prev_v = out_valid;
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; mode = 1'b0; accum_en = 1'b0;
    clear = 1'b0; out_ready = 1'b1; rnd = 1'b0;
    model_zero();
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_total", out_total, 0);
    check("rst_sat", sat, 0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready5", in_ready5, 1);

    // Directed words, first one on the first edge after reset release.
    send(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h8001, 1'b1, 1'b0, 1'b1, 1'b0);
    send(16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);

    // Back-pressure: result held for 10 cycles while inputs wiggle.
    send(16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_count", out_count, 4);
      check("hold_in_ready", in_ready, 0);
      in_data = 16'($urandom);
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Clear coinciding with a total update: clear wins.
    send(16'h0007, 1'b0, 1'b1, 1'b1, 1'b1);

    // Saturation on the 5-bit total.
    do_clear();
    send(16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    do_clear();

    // Reset mid-count aborts the word.
    send(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_zero();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    check("abort_out_total", out_total, 0);
    send(16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);

    // Random traffic with random gaps and back-pressure.
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
      send(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    rnd = 1'b0;
    out_ready = 1'b1;

    w = 0;
    while (q.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", q.size(), 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
